// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, grant/FSM enumerations and RotWord helper
package aes_pkg;

  typedef logic [31:0] word_t;

  // Word index width; covers the full 1..8 word range of a state.
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_STATE = 2'd1,
    GNT_KEY   = 2'd2
  } gnt_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fsm_e;

  // RotWord: rotate the word left by one byte.
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - four parallel AES forward S-box byte lookups
module aes_sbox (
  input  logic [7:0] b0_in,
  input  logic [7:0] b1_in,
  input  logic [7:0] b2_in,
  input  logic [7:0] b3_in,
  output logic [7:0] b0_out,
  output logic [7:0] b1_out,
  output logic [7:0] b2_out,
  output logic [7:0] b3_out
);

  localparam logic [7:0] SBOX_TAB [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign b0_out = SBOX_TAB[b0_in];
  assign b1_out = SBOX_TAB[b1_in];
  assign b2_out = SBOX_TAB[b2_in];
  assign b3_out = SBOX_TAB[b3_in];

endmodule

// File: rtl/sbox_scheduler.sv
// rtl/sbox_scheduler.sv - time-shares one 32-bit Sbox between SubBytes and SubWord clients
module sbox_scheduler
  import aes_pkg::*;
#(
  parameter int NWORDS    = 4,
  parameter bit KEY_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  st_start,
  input  logic [32*NWORDS-1:0]  st_in,
  output logic                  st_ready,
  output logic [32*NWORDS-1:0]  st_out,
  output logic                  st_done,
  input  logic                  k_req,
  input  logic [31:0]           k_word,
  input  logic                  k_rot,
  output logic                  k_gnt,
  output logic                  k_valid,
  output logic [31:0]           k_sub
);

  localparam int unsigned SW = 32 * NWORDS;

  fsm_e             fsm_q, fsm_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SW-1:0]    st_buf_q, st_buf_d;
  logic [SW-1:0]    st_out_q, st_out_d;
  logic             st_done_q, st_done_d;
  logic             k_valid_q, k_valid_d;
  word_t            k_sub_q, k_sub_d;
  gnt_e             last_gnt_q, last_gnt_d;

  gnt_e             gnt;
  word_t            st_word;
  word_t            key_word;
  word_t            sbox_in;
  word_t            sbox_out;

  // Slot arbiter: the preferred client yields only right after it won the previous slot.
  always_comb begin
    gnt = GNT_NONE;
    if (reset) begin
      gnt = GNT_NONE;
    end else if (fsm_q == IDLE) begin
      if (k_req) gnt = GNT_KEY;
    end else if (!k_req) begin
      gnt = GNT_STATE;
    end else if (KEY_FIRST) begin
      gnt = (last_gnt_q == GNT_KEY) ? GNT_STATE : GNT_KEY;
    end else begin
      gnt = (last_gnt_q == GNT_STATE) ? GNT_KEY : GNT_STATE;
    end
  end

  // Pick the latched state word addressed by idx; word 0 sits in the top bits.
  always_comb begin
    st_word = '0;
    for (int w = 0; w < NWORDS; w++) begin
      if (idx_q == IDX_W'(w)) st_word = st_buf_q[(NWORDS-1-w)*32 +: 32];
    end
  end

  assign key_word = k_rot ? rot_word(k_word) : k_word;
  assign sbox_in  = (gnt == GNT_KEY) ? key_word : st_word;

  aes_sbox u_sbox (
    .b0_in  (sbox_in[7:0]),
    .b1_in  (sbox_in[15:8]),
    .b2_in  (sbox_in[23:16]),
    .b3_in  (sbox_in[31:24]),
    .b0_out (sbox_out[7:0]),
    .b1_out (sbox_out[15:8]),
    .b2_out (sbox_out[23:16]),
    .b3_out (sbox_out[31:24])
  );

  // Next-state: accept in IDLE, step one state word per won slot, capture key results.
  always_comb begin
    fsm_d      = fsm_q;
    idx_d      = idx_q;
    st_buf_d   = st_buf_q;
    st_out_d   = st_out_q;
    st_done_d  = 1'b0;
    k_valid_d  = (gnt == GNT_KEY);
    k_sub_d    = (gnt == GNT_KEY) ? sbox_out : k_sub_q;
    last_gnt_d = gnt;

    if (fsm_q == IDLE) begin
      if (st_start) begin
        st_buf_d = st_in;
        idx_d    = '0;
        fsm_d    = BUSY;
      end
    end else if (gnt == GNT_STATE) begin
      for (int w = 0; w < NWORDS; w++) begin
        if (idx_q == IDX_W'(w)) st_out_d[(NWORDS-1-w)*32 +: 32] = sbox_out;
      end
      if (idx_q == IDX_W'(NWORDS - 1)) begin
        idx_d     = '0;
        fsm_d     = IDLE;
        st_done_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // State registers; reset drops any in-flight work and its pending pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q      <= IDLE;
      idx_q      <= '0;
      st_buf_q   <= '0;
      st_out_q   <= '0;
      st_done_q  <= 1'b0;
      k_valid_q  <= 1'b0;
      k_sub_q    <= '0;
      last_gnt_q <= GNT_STATE;
    end else begin
      fsm_q      <= fsm_d;
      idx_q      <= idx_d;
      st_buf_q   <= st_buf_d;
      st_out_q   <= st_out_d;
      st_done_q  <= st_done_d;
      k_valid_q  <= k_valid_d;
      k_sub_q    <= k_sub_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  assign st_ready = (fsm_q == IDLE);
  assign st_out   = st_out_q;
  assign st_done  = st_done_q;
  assign k_gnt    = (gnt == GNT_KEY);
  assign k_valid  = k_valid_q;
  assign k_sub    = k_sub_q;

endmodule

// File: tb/tb_sbox_scheduler.sv
// tb/tb_sbox_scheduler.sv - self-checking bench for sbox_scheduler
module tb_sbox_scheduler;

  localparam int NW = 4;
  localparam int SW = 32 * NW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          st_start;
  logic [SW-1:0] st_in;
  logic          k_req;
  logic [31:0]   k_word;
  logic          k_rot;

  logic          st_ready1, st_done1, k_gnt1, k_valid1;
  logic [SW-1:0] st_out1;
  logic [31:0]   k_sub1;
  logic          st_ready0, st_done0, k_gnt0, k_valid0;
  logic [SW-1:0] st_out0;
  logic [31:0]   k_sub0;

  sbox_scheduler #(.NWORDS(NW), .KEY_FIRST(1'b1)) u_k1 (
    .clk(clk), .reset(reset), .st_start(st_start), .st_in(st_in), .st_ready(st_ready1),
    .st_out(st_out1), .st_done(st_done1), .k_req(k_req), .k_word(k_word), .k_rot(k_rot),
    .k_gnt(k_gnt1), .k_valid(k_valid1), .k_sub(k_sub1)
  );

  sbox_scheduler #(.NWORDS(NW), .KEY_FIRST(1'b0)) u_k0 (
    .clk(clk), .reset(reset), .st_start(st_start), .st_in(st_in), .st_ready(st_ready0),
    .st_out(st_out0), .st_done(st_done0), .k_req(k_req), .k_word(k_word), .k_rot(k_rot),
    .k_gnt(k_gnt0), .k_valid(k_valid0), .k_sub(k_sub0)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_tab [256];

  // reference model state (KEY_FIRST=1 instance)
  logic          m_busy, m_done_pend, m_prev_gnt, m_prev_rot;
  int            m_slots;
  logic [SW-1:0] m_res;
  logic [31:0]   m_prev_word, m_ksub;

  // sampled outputs of the last tick
  logic          s_ready, s_done, s_gnt, s_valid, s0_gnt, s0_done;
  logic [SW-1:0] s_out, s0_out;
  logic [31:0]   s_ksub, s0_ksub;

  typedef struct {
    logic [31:0] w;
    logic        r;
    logic [31:0] exp;
  } kvec_t;
  kvec_t ktab [6];

  localparam logic [SW-1:0] VEC = 128'h59f67f73_7a883b6d_00000000_53535353;
  localparam logic [SW-1:0] RES = 128'hcb42d28f_dac4e23c_63636363_edededed;

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] r = x;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] w);
    logic [31:0] o;
    for (int i = 0; i < 4; i++) o[i*8 +: 8] = ref_tab[w[i*8 +: 8]];
    return o;
  endfunction

  function automatic logic [31:0] ref_key(input logic [31:0] w, input logic rot);
    return ref_word(rot ? {w[23:0], w[31:24]} : w);
  endfunction

  function automatic logic [SW-1:0] ref_state(input logic [SW-1:0] s);
    logic [SW-1:0] o;
    for (int i = 0; i < SW/8; i++) o[i*8 +: 8] = ref_tab[s[i*8 +: 8]];
    return o;
  endfunction

  // One clock: sample at negedge, check against the model, advance the model, return after posedge.
  task automatic tick();
    logic eg;
    @(negedge clk);
    s_ready = st_ready1; s_done = st_done1; s_gnt = k_gnt1; s_valid = k_valid1;
    s_out = st_out1; s_ksub = k_sub1;
    s0_gnt = k_gnt0; s0_done = st_done0; s0_out = st_out0; s0_ksub = k_sub0;
    if (!reset) begin
      if (!m_busy)     eg = k_req;
      else if (!k_req) eg = 1'b0;
      else             eg = !m_prev_gnt;
      if (m_prev_gnt) m_ksub = ref_key(m_prev_word, m_prev_rot);
      chk("k_gnt",    k_gnt1,    eg);
      chk("st_ready", st_ready1, !m_busy);
      chk("k_valid",  k_valid1,  m_prev_gnt);
      chk("k_sub",    k_sub1,    m_ksub);
      chk("st_done",  st_done1,  m_done_pend);
      if (m_done_pend) chk("st_out", st_out1, m_res);
      m_done_pend = 1'b0;
      if (!m_busy) begin
        if (st_start) begin
          m_busy  = 1'b1;
          m_slots = 0;
          m_res   = ref_state(st_in);
        end
      end else if (!eg) begin
        m_slots++;
        if (m_slots == NW) begin
          m_busy      = 1'b0;
          m_done_pend = 1'b1;
        end
      end
      m_prev_gnt  = eg;
      m_prev_word = k_word;
      m_prev_rot  = k_rot;
    end else begin
      m_busy      = 1'b0;
      m_done_pend = 1'b0;
      m_prev_gnt  = 1'b0;
      m_ksub      = '0;
      m_slots     = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d1, d0, ndone;
    logic [SW-1:0] r1, r0, va, vb;
    logic [7:0] inv_v, a_v;

    for (int b = 0; b < 256; b++) begin
      a_v   = b[7:0];
      inv_v = 8'h00;
      for (int x = 1; x < 256; x++) begin
        if (gmul(a_v, x[7:0]) == 8'h01) inv_v = x[7:0];
      end
      ref_tab[b] = inv_v ^ rotl8(inv_v, 1) ^ rotl8(inv_v, 2) ^ rotl8(inv_v, 3) ^ rotl8(inv_v, 4) ^ 8'h63;
    end

    ktab[0] = '{32'h09cf4f3c, 1'b1, 32'h8a84eb01};
    ktab[1] = '{32'h00000000, 1'b0, 32'h63636363};
    ktab[2] = '{32'h53535353, 1'b0, 32'hedededed};
    ktab[3] = '{32'h59f67f73, 1'b0, 32'hcb42d28f};
    ktab[4] = '{32'h12345678, 1'b1, 32'h18b1bcc9};
    ktab[5] = '{32'hffffffff, 1'b1, 32'h16161616};

    reset = 1'b1; st_start = 1'b0; st_in = '0; k_req = 1'b0; k_word = '0; k_rot = 1'b0;
    m_busy = 1'b0; m_done_pend = 1'b0; m_prev_gnt = 1'b0; m_prev_rot = 1'b0;
    m_slots = 0; m_res = '0; m_prev_word = '0; m_ksub = '0;

    // reset values
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_st_ready", s_ready, 1'b1);
    chk("rst_st_done",  s_done,  1'b0);
    chk("rst_st_out",   s_out,   '0);
    chk("rst_k_gnt",    s_gnt,   1'b0);
    chk("rst_k_valid",  s_valid, 1'b0);
    chk("rst_k_sub",    s_ksub,  '0);

    // key-only table
    for (int i = 0; i < 6; i++) begin
      k_req = 1'b1; k_word = ktab[i].w; k_rot = ktab[i].r;
      tick();
      chk("tbl_k_gnt", s_gnt, 1'b1);
      k_req = 1'b0;
      tick();
      chk("tbl_k_valid", s_valid, 1'b1);
      chk("tbl_k_sub",   s_ksub,  ktab[i].exp);
    end
    tick();

    // state only
    st_in = VEC; st_start = 1'b1;
    tick();
    st_start = 1'b0;
    d1 = -1;
    for (int c = 1; c <= 20 && d1 < 0; c++) begin
      tick();
      if (s_done) begin d1 = c; r1 = s_out; end
    end
    chk("state_latency", d1, 5);
    chk("state_result",  r1, RES);

    // contention, both arbitration polarities
    st_in = VEC; st_start = 1'b1; k_req = 1'b0;
    tick();
    st_start = 1'b0; k_req = 1'b1; k_word = 32'h0; k_rot = 1'b0;
    d1 = -1; d0 = -1; r1 = '0; r0 = '0;
    for (int c = 1; c <= 20 && (d1 < 0 || d0 < 0); c++) begin
      tick();
      if (c == 1) begin
        chk("cont_k1_first_slot_key",   s_gnt,  1'b1);
        chk("cont_k0_first_slot_state", s0_gnt, 1'b0);
      end
      if (s_done  && d1 < 0) begin d1 = c; r1 = s_out;  end
      if (s0_done && d0 < 0) begin d0 = c; r0 = s0_out; end
    end
    k_req = 1'b0;
    tick();
    chk("cont_k1_done_by_9", (d1 > 0 && d1 <= 9), 1'b1);
    chk("cont_k0_done_by_9", (d0 > 0 && d0 <= 9), 1'b1);
    chk("cont_k1_result", r1, RES);
    chk("cont_k0_result", r0, RES);
    chk("cont_k1_ksub", s_ksub,  32'h63636363);
    chk("cont_k0_ksub", s0_ksub, 32'h63636363);
    tick();

    // start ignored while busy
    va = 128'h00112233_44556677_8899aabb_ccddeeff;
    vb = 128'hdeadbeef_01234567_89abcdef_fedcba98;
    st_in = va; st_start = 1'b1;
    tick();
    st_start = 1'b0;
    tick();
    st_in = vb; st_start = 1'b1;
    tick();
    chk("busy_st_ready", s_ready, 1'b0);
    st_start = 1'b0; st_in = '0;
    ndone = 0; r1 = '0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (s_done) begin ndone++; r1 = s_out; end
    end
    chk("ignored_done_count", ndone, 1);
    chk("ignored_result", r1, 128'h638293c3_1bfc33f5_c4eeacea_4bc12816);

    // reset in the middle of BUSY
    st_in = VEC; st_start = 1'b1;
    tick();
    st_start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_st_out",   s_out,   '0);
    chk("midrst_st_ready", s_ready, 1'b1);
    chk("midrst_st_done",  s_done,  1'b0);
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (s_done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    st_in = '0; st_start = 1'b1;
    tick();
    st_start = 1'b0;
    d1 = -1;
    for (int c = 1; c <= 20 && d1 < 0; c++) begin
      tick();
      if (s_done) begin d1 = c; r1 = s_out; end
    end
    chk("zero_state_latency", d1, 5);
    chk("zero_state_result",  r1, {16{8'h63}});

    // randomized traffic against the model
    ndone = 0;
    s_gnt = 1'b0;
    for (int it = 0; it < 400; it++) begin
      if (!(k_req && !s_gnt)) begin
        k_req  = ($urandom_range(0, 2) != 0);
        k_word = $urandom;
        k_rot  = $urandom_range(0, 1);
      end
      st_start = ($urandom_range(0, 3) == 0);
      st_in    = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (s_done) ndone++;
    end
    k_req = 1'b0; st_start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (s_done) ndone++;
    end
    chk("random_some_done", (ndone > 0), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
